// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter lending one clear/increment counter to NREQ requesters for bursts of programmable length.
module counter_scheduler #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter INIT_VALUE = 8'hff,
  parameter int LW = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*LW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [NREQ-1:0]    done,
  output logic               clr,
  output logic               c_up,
  output logic [WIDTH-1:0]   q
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, DONE} state_t;
  state_t state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic [LW-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic found;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
      win_q <= '0;
      rem_q <= '0;
      q_q <= WIDTH'(INIT_VALUE);
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      rem_q <= rem_d;
      q_q <= q_d;
    end
  // first requester at or above the pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = 0; i < NREQ; i++)
      if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        pick = PW'((int'(ptr_q) + i) % NREQ);
      end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    win_d = win_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = CLEAR;
        win_d = pick;
        gnt_d = NREQ'(1) << pick;
        rem_d = len[int'(pick)*LW +: LW];
      end
      CLEAR: state_d = (rem_q != '0) ? COUNT : DONE;
      COUNT: begin
        rem_d = rem_q - 1'b1;
        state_d = (rem_q == LW'(1)) ? DONE : COUNT;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d = '0;
        ptr_d = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign clr = state_q == CLEAR;
  assign c_up = state_q == COUNT;
  assign busy = state_q != IDLE;
  assign done = (state_q == DONE) ? gnt_q : '0;
  assign gnt = gnt_q;
  assign q = q_q;
  assign q_d = clr ? WIDTH'(INIT_VALUE) : c_up ? q_q + 1'b1 : q_q;
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed vector table plus hand sequences for round-robin, wrap and mid-burst reset.
module tb_counter_scheduler;
  logic clk = 1'b0, rst_b = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] len = '0;
  logic [3:0] gnt, done;
  logic busy, clr, c_up;
  logic [7:0] q;
  int n = 0, fails = 0;

  counter_scheduler dut (
    .clk(clk), .rst_b(rst_b), .req(req), .len(len), .gnt(gnt),
    .busy(busy), .done(done), .clr(clr), .c_up(c_up), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [15:0] len;
    logic [3:0] gnt, done;
    logic busy, clr, c_up;
    logic [7:0] q;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    req = '0;
    tick();
    chk("rst_q", q, 8'hff);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {clr, c_up}, 0);
    rst_b = 1'b1;
  endtask

  int ord[4] = '{0, 2, 0, 2};

  initial begin
    // each row: inputs sampled at the edge, outputs expected just after it
    tv[0] = '{4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 1, 0, 8'hff};
    tv[1] = '{4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 0, 1, 8'hff};
    tv[2] = '{4'b0000, 16'h000f, 4'b0001, 4'b0000, 1, 0, 1, 8'h00};
    tv[3] = '{4'b0000, 16'h000f, 4'b0001, 4'b0000, 1, 0, 1, 8'h01};
    tv[4] = '{4'b0000, 16'h000f, 4'b0001, 4'b0001, 1, 0, 0, 8'h02};
    tv[5] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0, 8'h02};
    tv[6] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0, 8'h02};
    tv[7] = '{4'b0010, 16'h0000, 4'b0010, 4'b0000, 1, 1, 0, 8'h02};
    tv[8] = '{4'b0010, 16'h0000, 4'b0010, 4'b0010, 1, 0, 0, 8'hff};
    tv[9] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0, 8'hff};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = tv[i].req;
      len = tv[i].len;
      tick();
      chk($sformatf("vec%0d_gnt", i), gnt, tv[i].gnt);
      chk($sformatf("vec%0d_done", i), done, tv[i].done);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("vec%0d_clr", i), clr, tv[i].clr);
      chk($sformatf("vec%0d_cup", i), c_up, tv[i].c_up);
      chk($sformatf("vec%0d_q", i), q, tv[i].q);
    end

    do_reset();
    req = 4'b0101;
    len = 16'h0101;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 20 && gnt == 0; c++) tick();
      chk($sformatf("rr%0d_gnt", b), gnt, 1 << ord[b]);
      tick();
      tick();
      chk($sformatf("rr%0d_done", b), done, 1 << ord[b]);
      chk($sformatf("rr%0d_q", b), q, 8'h00);
      tick();
      chk($sformatf("rr%0d_idle", b), {busy, gnt}, 0);
    end

    do_reset();
    req = 4'b0001;
    len = 16'h000f;
    tick();
    chk("wrap_gnt", gnt, 4'b0001);
    req = '0;
    tick();
    chk("wrap_q_init", q, 8'hff);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk($sformatf("wrap_q%0d", k), q, k);
      chk($sformatf("wrap_cup%0d", k), c_up, 1);
    end
    tick();
    chk("wrap_done", done, 4'b0001);
    chk("wrap_done_q", q, 8'h0e);
    chk("wrap_done_cup", c_up, 0);

    do_reset();
    req = 4'b1000;
    len = 16'h5000;
    tick();
    tick();
    tick();
    chk("mid_counting", {gnt, c_up}, 5'b10001);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_q", q, 8'hff);
    chk("mid_gnt", gnt, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cup", c_up, 0);
    chk("mid_done", done, 0);
    req = 4'b1010;
    tick();
    chk("mid_hold_done", done, 0);
    rst_b = 1'b1;
    tick();
    chk("mid_restart_gnt", gnt, 4'b0010);
    chk("mid_restart_clr", clr, 1);
    req = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done[3]) chk("mid_no_done3", done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that shares one up-counter (clear/increment datapath, init value loaded on clear) between NREQ requesters. Each requester asks for a counting burst of a programmable length. The scheduler grants one requester at a time, clears the counter, pulses increment for the requested number of cycles, and signals completion to the grantee. It sits between requester logic and the counter instance it owns internally.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: counter width in bits.
- INIT_VALUE, 8'hff: value loaded into the counter on reset and on clear, truncated to WIDTH.
- LW, 4: width of each requester's burst-length field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req  in  NREQ  request per requester; level, held until the matching done.
- len  in  NREQ*LW  packed burst lengths; requester i uses len[i*LW +: LW].
- gnt  out  NREQ  one-hot grant, registered.
- busy  out  1  high whenever state is not IDLE.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- clr  out  1  clear strobe driven to the counter (observability).
- c_up  out  1  increment strobe driven to the counter (observability).
- q  out  WIDTH  counter value.

## Operation
- FSM states: IDLE, CLEAR, COUNT, DONE.
- Reset (asynchronous, any state):
  - state = IDLE; gnt = 0, done = 0, clr = 0, c_up = 0, busy = 0.
  - q = INIT_VALUE; remaining-count register = 0; round-robin pointer = 0.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching upward (with wrap) from the pointer index.
  - The winner's len is latched into the remaining-count register, gnt becomes one-hot on the winner, and the FSM moves to CLEAR.
  - With no request, the FSM stays in IDLE.
- CLEAR (exactly 1 cycle): clr = 1, c_up = 0.
  - At the end of the cycle q = INIT_VALUE.
  - Next state is COUNT if the latched len is nonzero, otherwise DONE.
- COUNT (exactly len cycles): c_up = 1, clr = 0.
  - q increments modulo 2^WIDTH on each edge and the remaining count decrements.
  - On the edge where the remaining count goes from 1 to 0, the FSM moves to DONE.
- DONE (exactly 1 cycle): done[winner] = 1, c_up = 0.
  - q holds INIT_VALUE + len (mod 2^WIDTH).
  - The pointer is set to winner+1 (mod NREQ). Next state is IDLE.
- gnt is held from CLEAR through DONE inclusive and is 0 in IDLE.
- q holds its value in IDLE until the next CLEAR.
- clr and c_up are never high in the same cycle.
- req and len are sampled only in IDLE.
  - A requester that drops req mid-burst still gets a complete burst and its done pulse.
  - Changes to len during a burst are ignored.
- A requester still holding req after its done competes again, but with the lowest priority.

## Timing
- Request at IDLE, sampled on edge k:
  - gnt and clr are high in cycle k+1 (CLEAR).
  - COUNT occupies cycles k+2 .. k+1+len.
  - done is high in cycle k+2+len.
  - IDLE is reached at k+3+len.
- Burst occupancy is len+2 cycles with gnt high, plus 1 IDLE cycle before the next grant.
- Back-to-back grant spacing is therefore len+3 cycles.
- Simultaneous requests in IDLE resolve in the same cycle; the pointer selects the winner.
- Reset asserted mid-burst:
  - All outputs take their reset values immediately, with no done pulse.
  - After release, arbitration restarts with requester 0 at highest priority.

## Test plan
- Reset: rst_b = 0 in any state -> q = ff, gnt = 0, done = 0, busy = 0, clr = c_up = 0.
- req[0] held with len0 = 3:
  - One CLEAR cycle (q becomes ff), then q = 00, 01, 02 over three COUNT cycles.
  - done[0] is high for 1 cycle with q = 02; gnt = 0001 for 5 cycles.
- req[0] and req[2] held continuously, len = 1 each -> grant order 0, 2, 0, 2; each done appears only to its grantee.
- len = 0 on req[1] -> CLEAR then DONE directly, c_up is never high, and q = ff at done[1].
- Wrap-around: len = 15 -> q sequence 00 .. 0e; done has q = 0e.
- rst_b pulsed low during COUNT of requester 3:
  - q = ff and gnt = 0 immediately; no done[3].
  - With req[1] and req[3] both high after release, requester 1 is granted first.
